// File: rtl/id_ex_stage_pkg.sv
// ID/EX stage shared definitions.
// ALU codes, EX control bundle and bubble constant.
package id_ex_stage_pkg;

  localparam int ID_EX_DW = 32;
  localparam int ID_EX_RW = 5;
  localparam int SHAMT_W  = 5;

  localparam logic [5:0] ALU_ADD = 6'b000000;
  localparam logic [5:0] ALU_SUB = 6'b000001;
  localparam logic [5:0] ALU_AND = 6'b011000;
  localparam logic [5:0] ALU_OR  = 6'b011110;
  localparam logic [5:0] ALU_XOR = 6'b010110;
  localparam logic [5:0] ALU_SLL = 6'b100000;
  localparam logic [5:0] ALU_SRL = 6'b100001;
  localparam logic [5:0] ALU_SRA = 6'b100011;

  typedef struct packed {
    logic [5:0] alufun;
    logic       sign;
    logic       src1;
    logic       src2;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
  } ex_ctl_t;

  localparam ex_ctl_t BUBBLE_CTL = '{
    alufun:   ALU_ADD,
    sign:     1'b0,
    src1:     1'b0,
    src2:     1'b0,
    regwrite: 1'b0,
    memread:  1'b0,
    memwrite: 1'b0
  };

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding mux for one source register.
// MEM result beats WB result beats the stored value; $0 never forwards.
module fwd_mux
  import id_ex_stage_pkg::*;
#(
  parameter int DW = ID_EX_DW,
  parameter int RW = ID_EX_RW
) (
  input  logic [RW-1:0] i_num,
  input  logic [DW-1:0] i_val,
  input  logic          i_mem_we,
  input  logic [RW-1:0] i_mem_addr,
  input  logic [DW-1:0] i_mem_data,
  input  logic          i_wb_we,
  input  logic [RW-1:0] i_wb_addr,
  input  logic [DW-1:0] i_wb_data,
  output logic [DW-1:0] o_val
);

  logic w_mem_hit;
  logic w_wb_hit;

  assign w_mem_hit = i_mem_we
                   && (i_mem_addr != '0)
                   && (i_mem_addr == i_num);
  assign w_wb_hit  = i_wb_we
                   && (i_wb_addr != '0)
                   && (i_wb_addr == i_num);

  // Pick the youngest in-flight producer of this register.
  always_comb begin
    o_val = i_val;
    priority case (1'b1)
      w_mem_hit: o_val = i_mem_data;
      w_wb_hit:  o_val = i_wb_data;
      default:   o_val = i_val;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with forwarding and load-use detect.
// Feeds ALU operands/controls and the EX/MEM store path.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DW    = ID_EX_DW,
  parameter int RW    = ID_EX_RW,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             ID_Valid,
  input  logic [DW-1:0]    ID_PC,
  input  logic [DW-1:0]    ID_RsData,
  input  logic [DW-1:0]    ID_RtData,
  input  logic [DW-1:0]    ID_Imm,
  input  logic [4:0]       ID_Shamt,
  input  logic [RW-1:0]    ID_Rs,
  input  logic [RW-1:0]    ID_Rt,
  input  logic [RW-1:0]    ID_WAddr,
  input  logic             ID_UsesRt,
  input  logic             ID_ALUSrc1,
  input  logic             ID_ALUSrc2,
  input  logic [5:0]       ID_ALUFun,
  input  logic             ID_Sign,
  input  logic             ID_RegWrite,
  input  logic             ID_MemRead,
  input  logic             ID_MemWrite,
  input  logic             MEM_RegWrite,
  input  logic [RW-1:0]    MEM_WAddr,
  input  logic [DW-1:0]    MEM_WData,
  input  logic             WB_RegWrite,
  input  logic [RW-1:0]    WB_WAddr,
  input  logic [DW-1:0]    WB_WData,
  output logic [DW-1:0]    A,
  output logic [DW-1:0]    B,
  output logic [5:0]       ALUFun,
  output logic             Sign,
  output logic [DW-1:0]    EX_RtData,
  output logic [DW-1:0]    EX_PC,
  output logic [RW-1:0]    EX_WAddr,
  output logic             EX_RegWrite,
  output logic             EX_MemRead,
  output logic             EX_MemWrite,
  output logic             EX_Valid,
  output logic             LoadUse,
  output logic [CNT_W-1:0] BubbleCnt
);

  logic                r_valid;
  ex_ctl_t             r_ctl;
  logic [DW-1:0]       r_pc;
  logic [DW-1:0]       r_rs_data;
  logic [DW-1:0]       r_rt_data;
  logic [DW-1:0]       r_imm;
  logic [SHAMT_W-1:0]  r_shamt;
  logic [RW-1:0]       r_rs;
  logic [RW-1:0]       r_rt;
  logic [RW-1:0]       r_waddr;
  logic [CNT_W-1:0]    r_bubble_cnt;

  logic [DW-1:0]       w_fwd_rs;
  logic [DW-1:0]       w_fwd_rt;
  logic [DW-1:0]       w_shamt_ext;
  logic                w_ld_hit_rs;
  logic                w_ld_hit_rt;
  logic                w_load_use;
  logic                w_cnt_full;
  ex_ctl_t             w_id_ctl;

  assign w_id_ctl = '{
    alufun:   ID_ALUFun,
    sign:     ID_Sign,
    src1:     ID_ALUSrc1,
    src2:     ID_ALUSrc2,
    regwrite: ID_RegWrite,
    memread:  ID_MemRead,
    memwrite: ID_MemWrite
  };

  fwd_mux #(
    .DW (DW),
    .RW (RW)
  ) u_fwd_rs (
    .i_num      (r_rs),
    .i_val      (r_rs_data),
    .i_mem_we   (MEM_RegWrite),
    .i_mem_addr (MEM_WAddr),
    .i_mem_data (MEM_WData),
    .i_wb_we    (WB_RegWrite),
    .i_wb_addr  (WB_WAddr),
    .i_wb_data  (WB_WData),
    .o_val      (w_fwd_rs)
  );

  fwd_mux #(
    .DW (DW),
    .RW (RW)
  ) u_fwd_rt (
    .i_num      (r_rt),
    .i_val      (r_rt_data),
    .i_mem_we   (MEM_RegWrite),
    .i_mem_addr (MEM_WAddr),
    .i_mem_data (MEM_WData),
    .i_wb_we    (WB_RegWrite),
    .i_wb_addr  (WB_WAddr),
    .i_wb_data  (WB_WData),
    .o_val      (w_fwd_rt)
  );

  assign w_ld_hit_rs = (r_waddr == ID_Rs);
  assign w_ld_hit_rt = ID_UsesRt && (r_waddr == ID_Rt);
  assign w_cnt_full  = &r_bubble_cnt;

  // A load in EX whose target ID needs must bubble; a stall already holds ID.
  always_comb begin
    w_load_use = 1'b0;
    if (!stall && r_valid && r_ctl.memread
        && (r_waddr != '0)) begin
      w_load_use = w_ld_hit_rs || w_ld_hit_rt;
    end
  end

  // Pipeline register: reset > flush > stall > load-use bubble > load.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid   <= 1'b0;
      r_ctl     <= BUBBLE_CTL;
      r_pc      <= '0;
      r_rs_data <= '0;
      r_rt_data <= '0;
      r_imm     <= '0;
      r_shamt   <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_waddr   <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_ctl   <= BUBBLE_CTL;
    end else if (stall) begin
      r_rs_data <= w_fwd_rs;
      r_rt_data <= w_fwd_rt;
    end else if (w_load_use) begin
      r_valid <= 1'b0;
      r_ctl   <= BUBBLE_CTL;
    end else begin
      r_valid   <= ID_Valid;
      r_ctl     <= w_id_ctl;
      r_pc      <= ID_PC;
      r_rs_data <= ID_RsData;
      r_rt_data <= ID_RtData;
      r_imm     <= ID_Imm;
      r_shamt   <= ID_Shamt;
      r_rs      <= ID_Rs;
      r_rt      <= ID_Rt;
      r_waddr   <= ID_WAddr;
    end
  end

  // Count load-use bubbles actually inserted; a flush in the same cycle wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bubble_cnt <= '0;
    end else if (!flush && w_load_use && !w_cnt_full) begin
      r_bubble_cnt <= r_bubble_cnt + 1'b1;
    end
  end

  assign w_shamt_ext = {{(DW-SHAMT_W){1'b0}}, r_shamt};

  assign A           = r_ctl.src1 ? w_shamt_ext : w_fwd_rs;
  assign B           = r_ctl.src2 ? r_imm : w_fwd_rt;
  assign EX_RtData   = w_fwd_rt;
  assign ALUFun      = r_valid ? r_ctl.alufun : ALU_ADD;
  assign Sign        = r_valid & r_ctl.sign;
  assign EX_PC       = r_pc;
  assign EX_WAddr    = r_waddr;
  assign EX_RegWrite = r_valid & r_ctl.regwrite;
  assign EX_MemRead  = r_valid & r_ctl.memread;
  assign EX_MemWrite = r_valid & r_ctl.memwrite;
  assign EX_Valid    = r_valid;
  assign LoadUse     = w_load_use;
  assign BubbleCnt   = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage.
// Expected values queue up with stimulus and are drained after each edge.
module tb_id_ex_stage;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  localparam int S_A   = 0;
  localparam int S_B   = 1;
  localparam int S_FUN = 2;
  localparam int S_SGN = 3;
  localparam int S_RTD = 4;
  localparam int S_PC  = 5;
  localparam int S_WA  = 6;
  localparam int S_RW  = 7;
  localparam int S_MR  = 8;
  localparam int S_MW  = 9;
  localparam int S_VLD = 10;
  localparam int S_LU  = 11;
  localparam int S_CNT = 12;

  logic          clk;
  logic          reset;
  logic          stall;
  logic          flush;
  logic          ID_Valid;
  logic [DW-1:0] ID_PC;
  logic [DW-1:0] ID_RsData;
  logic [DW-1:0] ID_RtData;
  logic [DW-1:0] ID_Imm;
  logic [4:0]    ID_Shamt;
  logic [RW-1:0] ID_Rs;
  logic [RW-1:0] ID_Rt;
  logic [RW-1:0] ID_WAddr;
  logic          ID_UsesRt;
  logic          ID_ALUSrc1;
  logic          ID_ALUSrc2;
  logic [5:0]    ID_ALUFun;
  logic          ID_Sign;
  logic          ID_RegWrite;
  logic          ID_MemRead;
  logic          ID_MemWrite;
  logic          MEM_RegWrite;
  logic [RW-1:0] MEM_WAddr;
  logic [DW-1:0] MEM_WData;
  logic          WB_RegWrite;
  logic [RW-1:0] WB_WAddr;
  logic [DW-1:0] WB_WData;
  logic [DW-1:0] A;
  logic [DW-1:0] B;
  logic [5:0]    ALUFun;
  logic          Sign;
  logic [DW-1:0] EX_RtData;
  logic [DW-1:0] EX_PC;
  logic [RW-1:0] EX_WAddr;
  logic          EX_RegWrite;
  logic          EX_MemRead;
  logic          EX_MemWrite;
  logic          EX_Valid;
  logic          LoadUse;
  logic [CW-1:0] BubbleCnt;

  typedef struct {
    int          sel;
    logic [31:0] v;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp;
  int   n_bad;
  int   exp_cnt;

  id_ex_stage #(
    .DW    (DW),
    .RW    (RW),
    .CNT_W (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .flush        (flush),
    .ID_Valid     (ID_Valid),
    .ID_PC        (ID_PC),
    .ID_RsData    (ID_RsData),
    .ID_RtData    (ID_RtData),
    .ID_Imm       (ID_Imm),
    .ID_Shamt     (ID_Shamt),
    .ID_Rs        (ID_Rs),
    .ID_Rt        (ID_Rt),
    .ID_WAddr     (ID_WAddr),
    .ID_UsesRt    (ID_UsesRt),
    .ID_ALUSrc1   (ID_ALUSrc1),
    .ID_ALUSrc2   (ID_ALUSrc2),
    .ID_ALUFun    (ID_ALUFun),
    .ID_Sign      (ID_Sign),
    .ID_RegWrite  (ID_RegWrite),
    .ID_MemRead   (ID_MemRead),
    .ID_MemWrite  (ID_MemWrite),
    .MEM_RegWrite (MEM_RegWrite),
    .MEM_WAddr    (MEM_WAddr),
    .MEM_WData    (MEM_WData),
    .WB_RegWrite  (WB_RegWrite),
    .WB_WAddr     (WB_WAddr),
    .WB_WData     (WB_WData),
    .A            (A),
    .B            (B),
    .ALUFun       (ALUFun),
    .Sign         (Sign),
    .EX_RtData    (EX_RtData),
    .EX_PC        (EX_PC),
    .EX_WAddr     (EX_WAddr),
    .EX_RegWrite  (EX_RegWrite),
    .EX_MemRead   (EX_MemRead),
    .EX_MemWrite  (EX_MemWrite),
    .EX_Valid     (EX_Valid),
    .LoadUse      (LoadUse),
    .BubbleCnt    (BubbleCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] obs(int sel);
    case (sel)
      S_A:     return A;
      S_B:     return B;
      S_FUN:   return {26'd0, ALUFun};
      S_SGN:   return {31'd0, Sign};
      S_RTD:   return EX_RtData;
      S_PC:    return EX_PC;
      S_WA:    return {27'd0, EX_WAddr};
      S_RW:    return {31'd0, EX_RegWrite};
      S_MR:    return {31'd0, EX_MemRead};
      S_MW:    return {31'd0, EX_MemWrite};
      S_VLD:   return {31'd0, EX_Valid};
      S_LU:    return {31'd0, LoadUse};
      default: return {{(32-CW){1'b0}}, BubbleCnt};
    endcase
  endfunction

  function automatic string nm(int sel);
    case (sel)
      S_A:     return "A";
      S_B:     return "B";
      S_FUN:   return "ALUFun";
      S_SGN:   return "Sign";
      S_RTD:   return "EX_RtData";
      S_PC:    return "EX_PC";
      S_WA:    return "EX_WAddr";
      S_RW:    return "EX_RegWrite";
      S_MR:    return "EX_MemRead";
      S_MW:    return "EX_MemWrite";
      S_VLD:   return "EX_Valid";
      S_LU:    return "LoadUse";
      default: return "BubbleCnt";
    endcase
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t",
               tag, got, want, $time);
    end
  endtask

  task automatic push(input int sel, input logic [31:0] v);
    exp_t e;
    e.sel = sel;
    e.v   = v;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk(nm(e.sel), obs(e.sel), e.v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic settle();
    #1;
    drain();
  endtask

  task automatic id_clear();
    ID_Valid    = 1'b0;
    ID_PC       = '0;
    ID_RsData   = '0;
    ID_RtData   = '0;
    ID_Imm      = '0;
    ID_Shamt    = '0;
    ID_Rs       = '0;
    ID_Rt       = '0;
    ID_WAddr    = '0;
    ID_UsesRt   = 1'b0;
    ID_ALUSrc1  = 1'b0;
    ID_ALUSrc2  = 1'b0;
    ID_ALUFun   = '0;
    ID_Sign     = 1'b0;
    ID_RegWrite = 1'b0;
    ID_MemRead  = 1'b0;
    ID_MemWrite = 1'b0;
  endtask

  task automatic bus_clear();
    MEM_RegWrite = 1'b0;
    MEM_WAddr    = '0;
    MEM_WData    = '0;
    WB_RegWrite  = 1'b0;
    WB_WAddr     = '0;
    WB_WData     = '0;
  endtask

  task automatic exp_zero();
    for (int s = S_A; s <= S_CNT; s++) begin
      if (s != S_LU) push(s, 32'd0);
    end
  endtask

  task automatic id_lw8();
    id_clear();
    ID_Valid    = 1'b1;
    ID_MemRead  = 1'b1;
    ID_RegWrite = 1'b1;
    ID_WAddr    = 5'd8;
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    exp_cnt = 0;
    reset   = 1'b1;
    stall   = 1'b0;
    flush   = 1'b0;
    id_clear();
    bus_clear();

    exp_zero();
    tick();
    reset = 1'b0;

    id_clear();
    ID_Valid    = 1'b1;
    ID_PC       = 32'h100;
    ID_Rs       = 5'd3;
    ID_RsData   = 32'd5;
    ID_Rt       = 5'd4;
    ID_RtData   = 32'd0;
    ID_ALUFun   = 6'b000001;
    ID_Sign     = 1'b1;
    ID_WAddr    = 5'd10;
    ID_RegWrite = 1'b1;
    push(S_A, 32'd5);
    push(S_B, 32'd0);
    push(S_FUN, 32'd1);
    push(S_SGN, 32'd1);
    push(S_VLD, 32'd1);
    push(S_PC, 32'h100);
    push(S_WA, 32'd10);
    push(S_RW, 32'd1);
    push(S_MR, 32'd0);
    tick();

    id_clear();
    ID_Valid    = 1'b1;
    ID_PC       = 32'h104;
    ID_ALUSrc1  = 1'b1;
    ID_Shamt    = 5'd7;
    ID_ALUSrc2  = 1'b1;
    ID_Imm      = 32'hFFFF_FFF0;
    ID_Rt       = 5'd4;
    ID_RtData   = 32'h22;
    ID_MemWrite = 1'b1;
    push(S_A, 32'd7);
    push(S_B, 32'hFFFF_FFF0);
    push(S_RTD, 32'h22);
    push(S_MW, 32'd1);
    push(S_RW, 32'd0);
    tick();

    reset = 1'b1;
    exp_zero();
    tick();
    reset = 1'b0;

    id_clear();
    ID_Valid  = 1'b1;
    ID_Rs     = 5'd7;
    ID_RsData = 32'd1;
    ID_Rt     = 5'd7;
    ID_RtData = 32'd2;
    push(S_A, 32'd1);
    push(S_B, 32'd2);
    tick();
    MEM_RegWrite = 1'b1;
    MEM_WAddr    = 5'd7;
    MEM_WData    = 32'hA;
    WB_RegWrite  = 1'b1;
    WB_WAddr     = 5'd7;
    WB_WData     = 32'hB;
    push(S_A, 32'hA);
    push(S_RTD, 32'hA);
    settle();
    MEM_RegWrite = 1'b0;
    push(S_A, 32'hB);
    push(S_B, 32'hB);
    settle();
    MEM_RegWrite = 1'b1;
    MEM_WAddr    = 5'd0;
    MEM_WData    = 32'hC;
    WB_RegWrite  = 1'b0;
    push(S_A, 32'd1);
    push(S_B, 32'd2);
    settle();
    bus_clear();

    id_lw8();
    push(S_MR, 32'd1);
    tick();
    id_clear();
    ID_Valid  = 1'b1;
    ID_PC     = 32'h200;
    ID_Rs     = 5'd1;
    ID_Rt     = 5'd8;
    ID_UsesRt = 1'b1;
    push(S_LU, 32'd1);
    settle();
    exp_cnt++;
    push(S_VLD, 32'd0);
    push(S_CNT, exp_cnt);
    push(S_MR, 32'd0);
    push(S_RW, 32'd0);
    tick();
    push(S_LU, 32'd0);
    settle();
    push(S_VLD, 32'd1);
    push(S_PC, 32'h200);
    push(S_CNT, exp_cnt);
    tick();

    id_lw8();
    tick();
    id_clear();
    ID_Valid  = 1'b1;
    ID_Rs     = 5'd1;
    ID_Rt     = 5'd8;
    ID_UsesRt = 1'b0;
    push(S_LU, 32'd0);
    settle();
    ID_Rs = 5'd8;
    push(S_LU, 32'd1);
    settle();
    stall = 1'b1;
    push(S_LU, 32'd0);
    settle();
    stall = 1'b0;
    id_clear();
    push(S_VLD, 32'd0);
    push(S_CNT, exp_cnt);
    tick();

    id_clear();
    ID_Valid  = 1'b1;
    ID_PC     = 32'h300;
    ID_Rs     = 5'd9;
    ID_RsData = 32'h11;
    push(S_A, 32'h11);
    tick();
    stall = 1'b1;
    id_clear();
    ID_Valid  = 1'b1;
    ID_PC     = 32'h400;
    ID_Rs     = 5'd2;
    ID_RsData = 32'h99;
    push(S_A, 32'h11);
    push(S_PC, 32'h300);
    push(S_VLD, 32'd1);
    tick();
    WB_RegWrite = 1'b1;
    WB_WAddr    = 5'd9;
    WB_WData    = 32'h55;
    push(S_A, 32'h55);
    tick();
    bus_clear();
    push(S_A, 32'h55);
    push(S_PC, 32'h300);
    tick();
    stall = 1'b0;
    push(S_A, 32'h55);
    settle();
    push(S_A, 32'h99);
    push(S_PC, 32'h400);
    tick();

    id_lw8();
    tick();
    id_clear();
    ID_Valid = 1'b1;
    ID_Rs    = 5'd8;
    flush    = 1'b1;
    push(S_LU, 32'd1);
    settle();
    push(S_VLD, 32'd0);
    push(S_CNT, exp_cnt);
    tick();
    flush = 1'b0;

    for (int i = 0; i < (1 << CW) + 2; i++) begin
      id_lw8();
      ID_Rs = 5'd8;
      push(S_VLD, 32'd1);
      push(S_MR, 32'd1);
      tick();
      push(S_LU, 32'd1);
      settle();
      if (exp_cnt < CNT_MAX) exp_cnt++;
      push(S_VLD, 32'd0);
      push(S_CNT, exp_cnt);
      tick();
    end
    push(S_CNT, CNT_MAX);
    settle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
